im_port_arbiter: RTL and testbench
==================================

// Module: im_port_arbiter
// PURPOSE
//  Shares the single-port instruction memory between the pipeline fetch stage (IF, read-only)
//  and the program loader/debug port (LD, read/write). Fixed IF priority with an LD
//  anti-starvation counter, plus a lock mode that freezes IF fetches during bulk program loads.
//  Sits between the IF stage/loader and the memory array; memory read data returns one cycle after grant.
// PARAMETERS
//  AW        32  byte-address width of if_addr/ld_addr
//  DW        32  data width
//  MEM_AW    10  word-address width to memory (1024 words)
//  MAX_WAIT  4   consecutive IF wins tolerated while LD pending; then LD forced (>=1)
//  WAIT_W    3   width of wait counter; must hold MAX_WAIT
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst_n      in   1       synchronous reset, active low
//  if_req     in   1       IF read request
//  if_addr    in   AW      IF byte address
//  if_gnt     out  1       IF request accepted this cycle (comb)
//  if_rvalid  out  1       IF read data valid (registered tag)
//  if_rdata   out  DW      IF read data (= mem_rdata)
//  ld_req     in   1       LD request
//  ld_we      in   1       LD write (1) / read (0)
//  ld_addr    in   AW      LD byte address
//  ld_wdata   in   DW      LD write data
//  ld_lock    in   1       LD requests exclusive ownership
//  ld_gnt     out  1       LD request accepted this cycle (comb)
//  ld_rvalid  out  1       LD read data valid (registered tag)
//  ld_rdata   out  DW      LD read data (= mem_rdata)
//  mem_en     out  1       memory access this cycle
//  mem_we     out  1       memory write
//  mem_addr   out  MEM_AW  word address = granted addr[MEM_AW+1:2]; upper/low 2 bits ignored
//  mem_wdata  out  DW      = ld_wdata
//  mem_rdata  in   DW      read data, valid the cycle after mem_en & !mem_we
//  locked     out  1       1 when FSM in S_LOCK (registered)
// BEHAVIOUR
//  FSM states: S_SHARE, S_LOCK. S_SHARE->S_LOCK at edge where ld_lock=1; S_LOCK->S_SHARE at edge
//   where ld_lock=0. Rising-edge cycle of ld_lock is still arbitrated as S_SHARE.
//  S_SHARE grant (comb, at most one gnt per cycle):
//   ld_req & (!if_req | wait_cnt==MAX_WAIT) -> ld_gnt; else if_req -> if_gnt; else none.
//  S_LOCK: ld_gnt=ld_req; if_gnt=0 always; wait_cnt held at 0.
//  wait_cnt: +1 (saturating at MAX_WAIT) when ld_req & if_gnt; cleared when ld_gnt or !ld_req.
//  mem_en = if_gnt|ld_gnt; mem_we = ld_gnt & ld_we; mem_addr from granted requester, 0 when idle.
//  Read latency 1: tag register {if_tag, ld_tag} set on read grant; if_rvalid/ld_rvalid = tag next cycle.
//   Writes never raise rvalid. rdata ports pass mem_rdata; meaningful only with rvalid.
//  Back-to-back grants every cycle allowed; no bubbles inserted by the arbiter.
//  Reset (rst_n=0 at edge): state=S_SHARE, wait_cnt=0, tags=0 -> if_rvalid=ld_rvalid=locked=0
//   the cycle after reset; grant outputs forced 0 while rst_n=0; in-flight read discarded.
//  Misaligned addresses are not an error: low 2 bits dropped.
// TESTING
//  1 reset, if_req=1 if_addr=0x10 -> if_gnt=1 mem_en=1 mem_addr=4; next cycle if_rvalid=1 if_rdata=mem[4].
//  2 if_req=ld_req=1 held, ld_we=0 -> if_gnt cycles 1-4, ld_gnt cycle 5, if_gnt cycle 6, repeats.
//  3 ld_lock=1, if_req=1 -> cycle 1 normal arbitration, then locked=1, if_gnt=0 indefinitely;
//    ld write 0xDEADBEEF to 0x40 -> mem_we=1 mem_addr=0x10 mem_wdata=0xDEADBEEF, no ld_rvalid.
//  4 drop ld_lock with if_req=1 -> locked=0 and if_gnt=1 the following cycle.
//  5 if_gnt at cycle N, rst_n=0 at edge N+1 -> if_rvalid=0 at N+1; state S_SHARE, wait_cnt=0.
//  6 ld_req alone, read 0x8 -> ld_gnt=1 mem_addr=2; next cycle ld_rvalid=1, if_rvalid=0.

Source files
------------

// File: rtl/im_port_arbiter.sv
// im_port_arbiter
// Shares the single-port instruction memory between the fetch stage (IF,
// read-only) and the loader/debug port (LD, read/write). IF has fixed
// priority, and LD is forced through after MAX_WAIT consecutive IF wins.
// A lock mode hands the memory exclusively to LD for bulk program loads.
// Read data returns one cycle after the grant. Each read is tagged with its
// requester so that the matching rvalid can be raised when the data arrives.
module im_port_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MEM_AW   = 10,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned WAIT_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  // fetch stage
  input  logic              if_req,
  input  logic [AW-1:0]     if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DW-1:0]     if_rdata,
  // loader / debug port
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DW-1:0]     ld_wdata,
  input  logic              ld_lock,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DW-1:0]     ld_rdata,
  // memory array
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  // status
  output logic              locked
);

  typedef enum logic [0:0] {
    S_SHARE = 1'b0,
    S_LOCK  = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              wait_max;
  logic              if_tag_q;
  logic              ld_tag_q;
  logic [MEM_AW-1:0] if_word;
  logic [MEM_AW-1:0] ld_word;

  // Byte addresses become word addresses; the low two bits and any bits
  // above the memory's reach are dropped, so misaligned requests are legal.
  assign if_word = if_addr[MEM_AW+1:2];
  assign ld_word = ld_addr[MEM_AW+1:2];

  // Only the word-address slice of each byte address reaches the memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr, ld_addr};

  // LD has waited out its full allowance of IF wins and must go next.
  assign wait_max = (wait_cnt_q == WAIT_W'(MAX_WAIT));

  // State register: shared arbitration or exclusive loader ownership.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the values from before this edge, whatever the order
    // in which the always_ff blocks execute.
    if (!rst_n) begin
      state_q <= S_SHARE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: follow ld_lock. The cycle in which ld_lock rises is still
  // arbitrated as shared, because the state only changes at the edge.
  always_comb begin
    // NOTE: each variable assigned here gets a default first, so that no path
    // through the block leaves it unassigned and infers a latch.
    state_d = state_q;
    unique case (state_q)
      S_SHARE: if (ld_lock)  state_d = S_LOCK;
      S_LOCK:  if (!ld_lock) state_d = S_SHARE;
      default: state_d = S_SHARE;
    endcase
  end

  // Grant decode: at most one grant per cycle, and none while reset is held.
  always_comb begin
    if_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        S_SHARE: begin
          if (ld_req && (!if_req || wait_max)) begin
            ld_gnt = 1'b1;
          end else if (if_req) begin
            if_gnt = 1'b1;
          end
        end
        S_LOCK: begin
          ld_gnt = ld_req;
        end
        default: begin
          if_gnt = 1'b0;
          ld_gnt = 1'b0;
        end
      endcase
    end
  end

  // Memory port: drive the address of the winner and park at 0 when idle.
  always_comb begin
    mem_en   = if_gnt | ld_gnt;
    mem_we   = ld_gnt & ld_we;
    mem_addr = '0;
    if (ld_gnt) begin
      mem_addr = ld_word;
    end else if (if_gnt) begin
      mem_addr = if_word;
    end
  end

  // Only the loader writes, so the write data is passed straight through.
  assign mem_wdata = ld_wdata;

  // Anti-starvation counter: counts IF wins while LD is kept waiting. It
  // restarts whenever LD is served or stops asking, and stays at 0 in lock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_LOCK || ld_gnt || !ld_req) begin
      wait_cnt_q <= '0;
    end else if (if_gnt && !wait_max) begin
      wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
    end
  end

  // Read tags: mark which requester owns the data that returns next cycle.
  // Reset clears them, so a read still in flight is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_tag_q <= 1'b0;
      ld_tag_q <= 1'b0;
    end else begin
      if_tag_q <= if_gnt;
      ld_tag_q <= ld_gnt & ~ld_we;
    end
  end

  assign if_rvalid = if_tag_q;
  assign ld_rvalid = ld_tag_q;
  assign if_rdata  = mem_rdata;
  assign ld_rdata  = mem_rdata;
  assign locked    = (state_q == S_LOCK);

  // Invariants of the arbitration, checked in simulation.
  a_one_grant: assert property (@(posedge clk) disable iff (!rst_n)
    !(if_gnt && ld_gnt));
  a_lock_blocks_if: assert property (@(posedge clk) disable iff (!rst_n)
    !(state_q == S_LOCK && if_gnt));
  a_one_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    !(if_rvalid && ld_rvalid));

endmodule

// File: tb/tb_im_port_arbiter.sv
// tb_im_port_arbiter
// The tests drive one request pattern per cycle and compare the grant and
// memory-port outputs inline. Each expected read is pushed to a scoreboard
// queue, and a monitor pops it on the next cycle to check rvalid and rdata.
module tb_im_port_arbiter;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int MEM_AW = 10;
  localparam int DEPTH  = 1 << MEM_AW;

  logic              clk;
  logic              rst_n;
  logic              if_req;
  logic [AW-1:0]     if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DW-1:0]     if_rdata;
  logic              ld_req;
  logic              ld_we;
  logic [AW-1:0]     ld_addr;
  logic [DW-1:0]     ld_wdata;
  logic              ld_lock;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [DW-1:0]     ld_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic              locked;

  typedef struct {
    bit            is_ld;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  bit            mon_on = 0;
  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  im_port_arbiter #(
    .AW(AW), .DW(DW), .MEM_AW(MEM_AW), .MAX_WAIT(4), .WAIT_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_lock(ld_lock), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
    .ld_rdata(ld_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: write on the edge, registered read data.
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  // Scoreboard consumer: at most one read is outstanding per cycle.
  always @(negedge clk) begin
    exp_t e;
    logic ei, el;
    logic [DW-1:0] ed;
    if (mon_on) begin
      ei = 1'b0;
      el = 1'b0;
      ed = '0;
      if (sb_q.size() > 0) begin
        e  = sb_q.pop_front();
        ei = !e.is_ld;
        el = e.is_ld;
        ed = e.data;
      end
      n_cmp++;
      if ({if_rvalid, ld_rvalid} !== {ei, el}) begin
        n_bad++;
        $display("FAIL rvalid @%0t: got if=%b ld=%b, expected if=%b ld=%b",
                 $time, if_rvalid, ld_rvalid, ei, el);
      end
      if (ei) begin
        n_cmp++;
        if (if_rdata !== ed) begin
          n_bad++;
          $display("FAIL if_rdata @%0t: got %h, expected %h", $time, if_rdata, ed);
        end
      end
      if (el) begin
        n_cmp++;
        if (ld_rdata !== ed) begin
          n_bad++;
          $display("FAIL ld_rdata @%0t: got %h, expected %h", $time, ld_rdata, ed);
        end
      end
    end
  end

  function automatic logic [MEM_AW-1:0] word(input logic [AW-1:0] a);
    return a[MEM_AW+1:2];
  endfunction

  // Applies one cycle of inputs just after the falling edge, then lets the
  // combinational outputs settle.
  task automatic drive(input logic rst, input logic ifr, input logic [AW-1:0] ia,
                       input logic ldr, input logic lwe, input logic [AW-1:0] la,
                       input logic [DW-1:0] wd, input logic lck);
    @(negedge clk);
    rst_n    = rst;
    if_req   = ifr;
    if_addr  = ia;
    ld_req   = ldr;
    ld_we    = lwe;
    ld_addr  = la;
    ld_wdata = wd;
    ld_lock  = lck;
    #1;
  endtask

  task automatic push_exp(input bit is_ld, input logic [MEM_AW-1:0] w);
    exp_t e;
    e.is_ld = is_ld;
    e.data  = ref_mem[w];
    sb_q.push_back(e);
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h8, '0, 1'b1);
    n_cmp++;
    if ({if_gnt, ld_gnt, mem_en} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_gnt: got gnt/en %b%b%b, expected 000", if_gnt, ld_gnt, mem_en);
    end
    idle();
    n_cmp++;
    if ({locked, mem_en, mem_addr} !== {1'b0, 1'b0, 10'd0}) begin
      n_bad++;
      $display("FAIL reset_state: got locked=%b en=%b addr=%h, expected 0 0 000",
               locked, mem_en, mem_addr);
    end
  endtask

  task automatic test_if_read();
    drive(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, '0, '0, 1'b0);
    n_cmp++;
    if ({if_gnt, ld_gnt, mem_en, mem_we, mem_addr} !== {4'b1010, 10'd4}) begin
      n_bad++;
      $display("FAIL if_read: got gnt/en/we/addr %b%b%b%b %h, expected 1010 004",
               if_gnt, ld_gnt, mem_en, mem_we, mem_addr);
    end
    push_exp(1'b0, 10'd4);
    idle();
  endtask

  task automatic test_ld_read();
    logic [AW-1:0] la [3];
    logic [AW-1:0] a;
    logic [MEM_AW-1:0] w;
    bit is_ld;
    la[0] = 32'h0000_0008;
    la[1] = 32'hFFFF_F00E;
    la[2] = 32'h0000_1013;
    for (int k = 0; k < 3; k++) begin
      is_ld = (k < 2);
      a = la[k];
      w = 10'((a >> 2) & 32'h3FF);
      drive(1'b1, !is_ld, a, is_ld, 1'b0, a, '0, 1'b0);
      n_cmp++;
      if ({if_gnt, ld_gnt, mem_en, mem_we, mem_addr} !== {!is_ld, is_ld, 2'b10, w}) begin
        n_bad++;
        $display("FAIL ld_read[%0d]: got gnt/en/we/addr %b%b%b%b %h, expected %b%b10 %h",
                 k, if_gnt, ld_gnt, mem_en, mem_we, mem_addr, !is_ld, is_ld, w);
      end
      push_exp(is_ld, w);
    end
    idle();
  endtask

  // Both requesters held: four IF wins, then one forced LD grant, repeating.
  task automatic test_fairness();
    logic [AW-1:0] ia, la;
    bit exp_ld;
    logic [MEM_AW-1:0] w;
    for (int k = 1; k <= 12; k++) begin
      ia = 32'h100 + 32'(k) * 4;
      la = 32'h300 + 32'(k) * 4;
      exp_ld = (k % 5 == 0);
      w = exp_ld ? word(la) : word(ia);
      drive(1'b1, 1'b1, ia, 1'b1, 1'b0, la, '0, 1'b0);
      n_cmp++;
      if ({if_gnt, ld_gnt, mem_addr} !== {!exp_ld, exp_ld, w}) begin
        n_bad++;
        $display("FAIL fairness[%0d]: got if=%b ld=%b addr=%h, expected if=%b ld=%b addr=%h",
                 k, if_gnt, ld_gnt, mem_addr, !exp_ld, exp_ld, w);
      end
      push_exp(exp_ld, w);
    end
    idle();
  endtask

  // Dropping ld_req for one cycle restarts the wait count.
  task automatic test_wait_clear();
    bit ldr, exp_ld;
    for (int k = 1; k <= 9; k++) begin
      ldr = (k != 4);
      exp_ld = (k == 9);
      drive(1'b1, 1'b1, 32'h40, ldr, 1'b0, 32'h44, '0, 1'b0);
      n_cmp++;
      if ({if_gnt, ld_gnt} !== {!exp_ld, exp_ld}) begin
        n_bad++;
        $display("FAIL wait_clear[%0d]: got if=%b ld=%b, expected if=%b ld=%b",
                 k, if_gnt, ld_gnt, !exp_ld, exp_ld);
      end
      push_exp(exp_ld, exp_ld ? 10'd17 : 10'd16);
    end
    idle();
  endtask

  task automatic test_lock();
    // Rising cycle of ld_lock is still shared: IF wins over a pending LD.
    drive(1'b1, 1'b1, 32'h20, 1'b1, 1'b0, 32'h24, '0, 1'b1);
    n_cmp++;
    if ({locked, if_gnt, ld_gnt, mem_addr} !== {3'b010, 10'd8}) begin
      n_bad++;
      $display("FAIL lock_first: got locked=%b if=%b ld=%b addr=%h, expected 0 1 0 008",
               locked, if_gnt, ld_gnt, mem_addr);
    end
    push_exp(1'b0, 10'd8);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, '0, '0, 1'b1);
      n_cmp++;
      if ({locked, if_gnt, ld_gnt, mem_en} !== 4'b1000) begin
        n_bad++;
        $display("FAIL lock_hold[%0d]: got locked=%b if=%b ld=%b en=%b, expected 1 0 0 0",
                 k, locked, if_gnt, ld_gnt, mem_en);
      end
    end
    drive(1'b1, 1'b1, 32'h20, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b1);
    n_cmp++;
    if ({if_gnt, ld_gnt, mem_en, mem_we, mem_addr, mem_wdata} !==
        {4'b0111, 10'h010, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL lock_write: got gnt/en/we %b%b%b%b addr=%h wdata=%h, expected 0111 010 deadbeef",
               if_gnt, ld_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    ref_mem[16] = 32'hDEAD_BEEF;
    drive(1'b1, 1'b1, 32'h20, 1'b1, 1'b0, 32'h40, '0, 1'b1);
    n_cmp++;
    if ({if_gnt, ld_gnt, mem_we, mem_addr} !== {3'b010, 10'h010}) begin
      n_bad++;
      $display("FAIL lock_read: got if=%b ld=%b we=%b addr=%h, expected 0 1 0 010",
               if_gnt, ld_gnt, mem_we, mem_addr);
    end
    push_exp(1'b1, 10'd16);
  endtask

  // Releasing the lock takes effect at the next edge, then arbitration resumes.
  task automatic test_unlock();
    bit exp_ld;
    bit exp_locked;
    for (int k = 1; k <= 6; k++) begin
      exp_locked = (k == 1);
      exp_ld = (k == 1) || (k == 6);
      drive(1'b1, 1'b1, 32'h30, 1'b1, 1'b0, 32'h34, '0, 1'b0);
      n_cmp++;
      if ({locked, if_gnt, ld_gnt} !== {exp_locked, !exp_ld, exp_ld}) begin
        n_bad++;
        $display("FAIL unlock[%0d]: got locked=%b if=%b ld=%b, expected %b %b %b",
                 k, locked, if_gnt, ld_gnt, exp_locked, !exp_ld, exp_ld);
      end
      push_exp(exp_ld, exp_ld ? 10'd13 : 10'd12);
    end
    idle();
  endtask

  // Grants every cycle, including a write directly followed by its readback.
  task automatic test_back_to_back();
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    int ph;
    bit exp_ld, exp_we;
    for (int k = 0; k < 8; k++) begin
      a  = 32'h80 + 32'(k / 4) * 4;
      wd = 32'h55AA_0000 + 32'(k);
      ph = k % 4;
      exp_ld = (ph < 2);
      exp_we = (ph == 0);
      drive(1'b1, ph >= 2, a, (ph < 2) || (ph == 3), exp_we, a, wd, 1'b0);
      n_cmp++;
      if ({if_gnt, ld_gnt, mem_en, mem_we, mem_addr} !==
          {!exp_ld, exp_ld, 1'b1, exp_we, word(a)}) begin
        n_bad++;
        $display("FAIL b2b[%0d]: got gnt/en/we %b%b%b%b addr=%h, expected %b%b1%b %h",
                 k, if_gnt, ld_gnt, mem_en, mem_we, mem_addr, !exp_ld, exp_ld, exp_we, word(a));
      end
      if (exp_we) ref_mem[word(a)] = wd;
      else push_exp(exp_ld, word(a));
    end
    idle();
  endtask

  // Reset mid-traffic returns to shared mode with a fresh wait count.
  task automatic test_reset_inflight();
    bit exp_ld;
    for (int k = 1; k <= 2; k++) begin
      drive(1'b1, 1'b1, 32'h50, 1'b1, 1'b0, 32'h54, '0, 1'b0);
      push_exp(1'b0, 10'd20);
    end
    drive(1'b0, 1'b1, 32'h50, 1'b1, 1'b0, 32'h54, '0, 1'b1);
    n_cmp++;
    if ({if_gnt, ld_gnt, mem_en} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_inflight_gnt: got gnt/en %b%b%b, expected 000", if_gnt, ld_gnt, mem_en);
    end
    for (int k = 1; k <= 5; k++) begin
      exp_ld = (k == 5);
      drive(1'b1, 1'b1, 32'h50, 1'b1, 1'b0, 32'h54, '0, 1'b0);
      n_cmp++;
      if ({locked, if_gnt, ld_gnt} !== {1'b0, !exp_ld, exp_ld}) begin
        n_bad++;
        $display("FAIL rst_inflight[%0d]: got locked=%b if=%b ld=%b, expected 0 %b %b",
                 k, locked, if_gnt, ld_gnt, !exp_ld, exp_ld);
      end
      push_exp(exp_ld, exp_ld ? 10'd21 : 10'd20);
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
      ref_mem[i] = 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
    end
    mem_rdata = '0;
    rst_n     = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    ld_req    = 1'b0;
    ld_we     = 1'b0;
    ld_addr   = '0;
    ld_wdata  = '0;
    ld_lock   = 1'b0;
    mon_on    = 1'b1;

    test_reset();
    test_if_read();
    test_ld_read();
    test_fairness();
    test_wait_clear();
    test_lock();
    test_unlock();
    test_back_to_back();
    test_reset_inflight();
    idle();
    idle();

    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d reads outstanding, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
